controle_multiciclo: RTL and testbench
======================================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles a memory access waits for mem_ready.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports are listed below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 opcode  in  7  instr[6:0], valid from DECODE onward.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory access complete this cycle.
REQ-008 pc_write, ir_write, reg_write, mem_read, mem_write, iord, mem_to_reg, pc_src  out  1 each  datapath strobes and selects.
REQ-009 alu_src_a  out  2  operand A select: 00 PC, 01 old PC, 10 rs1.
REQ-010 alu_src_b  out  2  operand B select: 00 rs2, 01 constant 4, 10 imm.
REQ-011 alu_op  out  2  operation class: 00 add, 01 sub, 10 funct-decoded.
REQ-012 estado  out  4  current state encoding.
REQ-013 parado  out  1  controller halted.
REQ-014 erro  out  2  halt cause: 00 none, 01 illegal opcode, 10 memory timeout.
REQ-015 instr_count  out  32  retired-instruction counter.

Function
REQ-016 The states SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, HALT=10.
REQ-017 Any output not listed for a state SHALL be 0.
REQ-018 FETCH SHALL drive iord=0, mem_read=1, alu_src_a=00, alu_src_b=01, alu_op=00 and pc_src=0.
REQ-019 In FETCH, ir_write and pc_write SHALL pulse only in the cycle mem_ready=1, and the next state SHALL be DECODE.
REQ-020 DECODE SHALL drive alu_src_a=01, alu_src_b=10 and alu_op=00 (branch target into ALUOut).
REQ-021 DECODE SHALL dispatch on opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- any other opcode -> HALT with erro=01
REQ-022 MEMADR SHALL drive alu_src_a=10, alu_src_b=10 and alu_op=00; it SHALL go to MEMREAD if opcode is a load, otherwise to MEMWRITE.
REQ-023 MEMREAD SHALL drive iord=1 and mem_read=1, and SHALL advance to MEMWB when mem_ready=1.
REQ-024 MEMWB SHALL drive reg_write=1 and mem_to_reg=1, then go to FETCH.
REQ-025 MEMWRITE SHALL drive iord=1 and mem_write=1, and SHALL go to FETCH when mem_ready=1.
REQ-026 EXEC_R SHALL drive alu_src_a=10, alu_src_b=00 and alu_op=10.
REQ-027 EXEC_I SHALL drive alu_src_a=10, alu_src_b=10 and alu_op=10.
REQ-028 Both EXEC_R and EXEC_I SHALL go to ALUWB, which SHALL drive reg_write=1 and mem_to_reg=0, then go to FETCH.
REQ-029 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1 and pc_write=zero (combinational), then go to FETCH.
REQ-030 The wait counter SHALL clear on entry to FETCH, MEMREAD or MEMWRITE and increment each cycle mem_ready=0 in those states.
REQ-031 When the wait counter reaches TIMEOUT, the next state SHALL be HALT with erro=10, and no strobe SHALL be issued that cycle.
REQ-032 mem_ready=1 in the same cycle the count reaches TIMEOUT SHALL win: the access completes normally.
REQ-033 HALT SHALL hold all strobes at 0 and parado=1 until rst; erro SHALL hold its cause.
REQ-034 instr_count SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH, and SHALL wrap 0xFFFFFFFF -> 0.
REQ-035 mem_read and mem_write SHALL never both be 1.
REQ-036 pc_write SHALL be at most one cycle per instruction.

Reset
REQ-037 With rst=1 at a rising edge, the next state SHALL be FETCH, with wait counter=0, instr_count=0, erro=00 and parado=0, regardless of the current state.
REQ-038 Reset asserted mid-access (e.g., in MEMREAD) SHALL abandon the access with no reg_write or pc_write issued.

Verification
REQ-039 Release rst with mem_ready=1 and opcode=0110011 -> states 0,1,6,8,0; reg_write high in exactly one cycle; instr_count=1.
REQ-040 Load 0000011 with mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; mem_to_reg=1 in MEMWB.
REQ-041 beq 1100011 with zero=1, then zero=0 -> pc_write in BRANCH only in the first case; pc_src=1; instr_count advances by 2.
REQ-042 opcode=1111111 -> HALT after DECODE; parado=1; erro=01; all strobes 0 for 20 cycles.
REQ-043 TIMEOUT=16 with mem_ready held 0 in FETCH -> HALT after 16 wait cycles with erro=10; mem_ready=1 on cycle 16 -> normal DECODE.
REQ-044 rst pulse during MEMWRITE -> next state FETCH; mem_write drops to 0; instr_count=0.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multi-cycle RISC-V style control FSM: drives datapath strobes/selects,
// bounds each memory wait with TIMEOUT and counts retired instructions.
module controle_multiciclo #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  estado,
  output logic        parado,
  output logic [1:0]  erro,
  output logic [31:0] instr_count
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [1:0]    erro_q, erro_d;
  logic          timed_out;
  logic          wait_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      erro_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      erro_q  <= erro_d;
    end
  end

  // mem_ready in the TIMEOUT cycle still completes the access
  assign timed_out  = (wait_q == WW'(TIMEOUT)) && !mem_ready;
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    erro_d     = erro_q;
    wait_d     = wait_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        if (timed_out) begin
          state_d = S_HALT;
          erro_d  = 2'b10;
        end else begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d = S_HALT;
            erro_d  = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (timed_out) begin
          state_d = S_HALT;
          erro_d  = 2'b10;
        end else begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        cnt_d      = cnt_q + 32'd1;
      end
      S_MEMWRITE: begin
        if (timed_out) begin
          state_d = S_HALT;
          erro_d  = 2'b10;
        end else begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        cnt_d     = cnt_q + 32'd1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
        state_d   = S_FETCH;
        cnt_d     = cnt_q + 32'd1;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    if (state_d != state_q)
      wait_d = '0;
    else if (wait_state && !mem_ready)
      wait_d = wait_q + 1'b1;

    // an access interrupted by reset must not commit anything
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
    end
  end

  assign estado      = state_q;
  assign parado      = (state_q == S_HALT);
  assign erro        = erro_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed vector table, corner sequences and
// randomized traffic checked against a behavioural model every cycle.
module tb_controle_multiciclo;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, zero, mem_ready;
  logic [6:0]  opcode;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, iord, mem_to_reg, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, erro;
  logic [3:0]  estado;
  logic        parado;
  logic [31:0] instr_count;

  controle_multiciclo #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .estado(estado), .parado(parado),
    .erro(erro), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // [13]pcw [12]irw [11]rw [10]mrd [9]mwr [8]iord [7]mtr [6]pcs [5:4]a [3:2]b [1:0]op
  logic [13:0] dut_vec;
  assign dut_vec = {pc_write, ir_write, reg_write, mem_read, mem_write, iord,
                    mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: state numbers and output table from the spec ----
  logic [13:0] base [0:10];
  int          m_st = 0, m_wait = 0;
  logic [31:0] m_cnt = 0;
  logic [1:0]  m_err = 0;

  function automatic logic [13:0] mkb(input bit pcw, irw, rw, mrd, mwr, io, mtr, pcs,
                                      input bit [1:0] a, b, op);
    return {pcw, irw, rw, mrd, mwr, io, mtr, pcs, a, b, op};
  endfunction

  function automatic logic [13:0] m_out(input logic r, input logic z, input logic m);
    logic [13:0] v;
    if (r || m_st == 10) return 14'd0;
    if ((m_st == 0 || m_st == 3 || m_st == 5) && m_wait >= TO && !m) return 14'd0;
    v = base[m_st];
    if (m_st == 0) begin v[13] = m; v[12] = m; end
    if (m_st == 9) v[13] = z;
    return v;
  endfunction

  task automatic m_step(input logic r, input logic [6:0] op, input logic m);
    int nx;
    if (r) begin m_st = 0; m_wait = 0; m_cnt = 0; m_err = 0; return; end
    nx = m_st;
    case (m_st)
      0, 3, 5: begin
        if (m) nx = (m_st == 0) ? 1 : (m_st == 3) ? 4 : 0;
        else if (m_wait >= TO) begin nx = 10; m_err = 2'd2; end
      end
      1: case (op)
           7'h03, 7'h23: nx = 2;
           7'h33:        nx = 6;
           7'h13:        nx = 7;
           7'h63:        nx = 9;
           default: begin nx = 10; m_err = 2'd1; end
         endcase
      2: nx = (op == 7'h03) ? 3 : 5;
      4, 8, 9: nx = 0;
      6, 7: nx = 8;
      default: ;
    endcase
    if (nx == 0 && (m_st == 4 || m_st == 5 || m_st == 8 || m_st == 9)) m_cnt++;
    if (nx != m_st) m_wait = 0;
    else if ((m_st == 0 || m_st == 3 || m_st == 5) && !m) m_wait++;
    m_st = nx;
  endtask

  // ---- one clock: drive, compare against model, advance model ----
  logic [13:0] snap_out;
  int          snap_st;
  logic [31:0] snap_cnt;
  logic [1:0]  snap_err;

  task automatic cycle(input logic r, input logic [6:0] op, input logic z, input logic m);
    @(negedge clk);
    rst = r; opcode = op; zero = z; mem_ready = m;
    #2;
    snap_out = dut_vec; snap_st = int'(estado); snap_cnt = instr_count; snap_err = erro;
    chk("strobes", {18'd0, dut_vec}, {18'd0, m_out(r, z, m)});
    chk("estado", {28'd0, estado}, m_st);
    chk("parado", {31'd0, parado}, {31'd0, (m_st == 10)});
    chk("erro", {30'd0, erro}, {30'd0, m_err});
    chk("instr_count", instr_count, m_cnt);
    chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
    @(posedge clk);
    m_step(r, op, m);
  endtask

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       z;
    logic       mr;
    int         st;
    int         cnt;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic [6:0] op, input logic z, input logic mr,
                              input int st, input int cnt);
    vec_t v;
    v.rst = 1'b0; v.op = op; v.z = z; v.mr = mr; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  logic [6:0] legal [0:5];

  initial begin
    base[0]  = mkb(0,0,0,1,0,0,0,0, 2'b00, 2'b01, 2'b00);
    base[1]  = mkb(0,0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00);
    base[2]  = mkb(0,0,0,0,0,0,0,0, 2'b10, 2'b10, 2'b00);
    base[3]  = mkb(0,0,0,1,0,1,0,0, 2'b00, 2'b00, 2'b00);
    base[4]  = mkb(0,0,1,0,0,0,1,0, 2'b00, 2'b00, 2'b00);
    base[5]  = mkb(0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00);
    base[6]  = mkb(0,0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10);
    base[7]  = mkb(0,0,0,0,0,0,0,0, 2'b10, 2'b10, 2'b10);
    base[8]  = mkb(0,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    base[9]  = mkb(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b01);
    base[10] = 14'd0;
    legal[0] = 7'h03; legal[1] = 7'h23; legal[2] = 7'h33;
    legal[3] = 7'h13; legal[4] = 7'h63; legal[5] = 7'h33;

    // R-type, load with two stalls, beq taken then not taken
    tv.push_back(mk(7'h33,0,1, 0,0)); tv.push_back(mk(7'h33,0,1, 1,0));
    tv.push_back(mk(7'h33,0,1, 6,0)); tv.push_back(mk(7'h33,0,1, 8,0));
    tv.push_back(mk(7'h03,0,1, 0,1)); tv.push_back(mk(7'h03,0,1, 1,1));
    tv.push_back(mk(7'h03,0,0, 2,1)); tv.push_back(mk(7'h03,0,0, 3,1));
    tv.push_back(mk(7'h03,0,0, 3,1)); tv.push_back(mk(7'h03,0,1, 3,1));
    tv.push_back(mk(7'h03,0,1, 4,1));
    tv.push_back(mk(7'h63,1,1, 0,2)); tv.push_back(mk(7'h63,1,1, 1,2));
    tv.push_back(mk(7'h63,1,1, 9,2));
    tv.push_back(mk(7'h63,0,1, 0,3)); tv.push_back(mk(7'h63,0,1, 1,3));
    tv.push_back(mk(7'h63,0,1, 9,3));
    tv.push_back(mk(7'h33,0,0, 0,4));

    rst = 1'b1; opcode = 7'h33; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    m_step(1'b1, 7'h33, 1'b1);
    cycle(1'b1, 7'h33, 0, 1);

    foreach (tv[i]) begin
      cycle(tv[i].rst, tv[i].op, tv[i].z, tv[i].mr);
      chk($sformatf("vec%0d_estado", i), snap_st, tv[i].st);
      chk($sformatf("vec%0d_count", i), snap_cnt, tv[i].cnt);
      if (tv[i].st == 9) chk($sformatf("vec%0d_pcw", i), {31'd0, snap_out[13]}, {31'd0, tv[i].z});
      if (tv[i].st == 4) chk("memwb_mtr", {31'd0, snap_out[7]}, 32'd1);
    end

    // illegal opcode halts and stays quiet
    cycle(1'b1, 7'h7f, 0, 1);
    cycle(1'b0, 7'h7f, 0, 1);
    cycle(1'b0, 7'h7f, 0, 1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 7'($urandom), 1'($urandom), 1'($urandom));
      chk("illegal_halt", snap_st, 10);
      chk("illegal_erro", {30'd0, snap_err}, 32'd1);
      chk("illegal_quiet", {18'd0, snap_out}, 32'd0);
    end

    // fetch timeout
    cycle(1'b1, 7'h33, 0, 0);
    for (int k = 0; k < TO; k++) cycle(1'b0, 7'h33, 0, 0);
    cycle(1'b0, 7'h33, 0, 0);
    chk("to_cycle_quiet", {18'd0, snap_out}, 32'd0);
    chk("to_cycle_state", snap_st, 0);
    cycle(1'b0, 7'h33, 0, 1);
    chk("to_halt", snap_st, 10);
    chk("to_erro", {30'd0, snap_err}, 32'd2);

    // ready arriving in the timeout cycle wins
    cycle(1'b1, 7'h33, 0, 0);
    for (int k = 0; k < TO; k++) cycle(1'b0, 7'h33, 0, 0);
    cycle(1'b0, 7'h33, 0, 1);
    chk("to_win_irw", {31'd0, snap_out[12]}, 32'd1);
    cycle(1'b0, 7'h33, 0, 1);
    chk("to_win_decode", snap_st, 1);

    // reset during a store
    cycle(1'b1, 7'h33, 0, 1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 7'h33, 0, 1);
    cycle(1'b0, 7'h23, 0, 1);
    cycle(1'b0, 7'h23, 0, 1);
    cycle(1'b0, 7'h23, 0, 0);
    cycle(1'b0, 7'h23, 0, 0);
    chk("st_memwrite", snap_st, 5);
    chk("st_mw_high", {31'd0, snap_out[9]}, 32'd1);
    chk("st_cnt_before", snap_cnt, 1);
    cycle(1'b1, 7'h23, 0, 1);
    chk("st_rst_quiet", {18'd0, snap_out}, 32'd0);
    cycle(1'b0, 7'h23, 0, 0);
    chk("st_after_fetch", snap_st, 0);
    chk("st_after_mw", {31'd0, snap_out[9]}, 32'd0);
    chk("st_after_cnt", snap_cnt, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 19) == 0) ? 7'($urandom) : legal[$urandom_range(0, 5)];
      cycle(($urandom_range(0, 49) == 0), op, 1'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
